// File: rtl/conv_pkg.sv
// Shared defaults and types for the rate-1/N feed-forward convolutional encoder.
package conv_pkg;

  localparam int          DEF_K   = 3;
  localparam int          DEF_N   = 2;
  localparam logic [5:0]  DEF_GEN = 6'b101_111;

  typedef enum logic {DATA, FLUSH} state_t;

  // Flush counter width; it must hold K-1.
  function automatic int cnt_width(input int k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

  localparam int CW = cnt_width(DEF_K);

endpackage

// File: rtl/conv_encoder_if.sv
// Valid/ready bus of the encoder: serial bits in, N-bit symbols out.
interface conv_encoder_if #(
  parameter int N = 2
);
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sym;
  logic         out_last;

  modport master (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_gen_xor.sv
// One generator polynomial: parity of the tapped input window. Purely combinational.
module conv_gen_xor #(
  parameter int         K = 3,
  parameter logic [K-1:0] G = '1
) (
  input  logic [K-1:0] u,
  output logic         y
);
  assign y = ^(G & u);
endmodule

// File: rtl/conv_encoder.sv
// Rate-1/N convolutional encoder; CONV_ENCODER_TAIL_EN appends K-1 zero tail symbols per frame.
// One-cycle registered output; a stalled symbol holds and blocks input until out_ready.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int             K   = DEF_K,
  parameter int             N   = DEF_N,
  parameter logic [N*K-1:0] GEN = (N*K)'(DEF_GEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_encoder_if.master bus,
  output logic          busy
);

  logic [K-2:0] sr;
  logic [K-1:0] u;
  logic [N-1:0] sym_next;
  logic         slot_free;
  logic         accept;

  assign slot_free = !bus.out_valid || bus.out_ready;

`ifdef CONV_ENCODER_TAIL_EN
  localparam int CNT_W = cnt_width(K);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             flush_step;

  // Tail symbols shift zeros in, regardless of whatever sits on in_bit.
  assign u            = {(state == DATA) & bus.in_bit, sr};
  assign bus.in_ready = (state == DATA) && slot_free;
  assign flush_step   = (state == FLUSH) && slot_free;
  assign busy         = (state == FLUSH) || bus.out_valid;
`else
  assign u            = {bus.in_bit, sr};
  assign bus.in_ready = slot_free;
  assign busy         = bus.out_valid;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_gen
    conv_gen_xor #(
      .K (K),
      .G (GEN[gi*K +: K])
    ) u_gen_xor (
      .u (u),
      .y (sym_next[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sym   <= '0;
      bus.out_last  <= 1'b0;
      sr            <= '0;
`ifdef CONV_ENCODER_TAIL_EN
      state         <= DATA;
      cnt           <= '0;
`endif
    end else begin
      if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_sym   <= sym_next;
        sr            <= u[K-1:1];
`ifdef CONV_ENCODER_TAIL_EN
        bus.out_last  <= 1'b0;
        if (bus.in_last) begin
          state <= FLUSH;
          cnt   <= CNT_W'(K-1);
        end
`else
        bus.out_last  <= bus.in_last;
        if (bus.in_last) begin
          sr <= '0;
        end
`endif
      end
`ifdef CONV_ENCODER_TAIL_EN
      if (flush_step) begin
        bus.out_valid <= 1'b1;
        bus.out_sym   <= sym_next;
        bus.out_last  <= (cnt == CNT_W'(1));
        sr            <= u[K-1:1];
        cnt           <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          sr    <= '0;
          state <= DATA;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed and scoreboarded bench for conv_encoder (K=3/N=2 and K=4/N=3 instances).
module tb_conv_encoder;
  import conv_pkg::*;

`ifdef CONV_ENCODER_TAIL_EN
  localparam int TAIL_B = 3;
`else
  localparam int TAIL_B = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;

  always #5 clk = ~clk;

  conv_encoder_if #(.N(2)) bus_a ();
  conv_encoder_if #(.N(3)) bus_b ();

  conv_encoder #(.K(3), .N(2), .GEN(6'b101_111)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a), .busy (busy_a)
  );

  conv_encoder #(.K(4), .N(3), .GEN(12'b1101_1011_1111)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b), .busy (busy_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- instance A: out_ready driver and output monitor
  bit         bp_en = 1'b0;
  int         bp_idx = 0;
  logic [5:0] bp_pat = 6'b101001;  // 1,0,0,1,0,1 from bit 0

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bus_a.out_ready = bp_pat[bp_idx % 6];
      bp_idx++;
    end else begin
      bus_a.out_ready = 1'b1;
    end
  end

  logic [2:0] qa[$];
  bit         stall_prev = 1'b0;
  logic [2:0] held;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) chk("a_stall_hold", {bus_a.out_last, bus_a.out_sym}, held);
      if (bus_a.out_valid && !bus_a.out_ready) chk("a_stall_in_ready", bus_a.in_ready, 0);
      if (bus_a.out_valid && bus_a.out_ready) qa.push_back({bus_a.out_last, bus_a.out_sym});
      stall_prev = bus_a.out_valid && !bus_a.out_ready;
      held       = {bus_a.out_last, bus_a.out_sym};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic wait_acc_a();
    int t = 0;
    @(negedge clk);
    while (!bus_a.in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("a_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // bits[0] is sent first; in_last rides on the final bit when with_last is set
  task automatic send_a(input logic [15:0] bits, input int len, input bit with_last);
    @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_bit   = bits[i];
      bus_a.in_last  = with_last && (i == len - 1);
      wait_acc_a();
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  // exps packs {last, sym} per symbol, first symbol in the low 3 bits
  task automatic expect_a(input string tag, input logic [23:0] exps, input int n);
    int t = 0;
    while (qa.size() < n && t < 80) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, qa.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < qa.size()) chk(tag, qa[i], exps[i*3 +: 3]);
    end
    qa.delete();
  endtask

  // ---------------- instance B: reference model and scoreboard
  logic [3:0] qb[$];
  logic [2:0] hb = 3'b000;
  int         nb_sym = 0;

  always @(posedge clk) begin
    #1;
    bus_b.out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [2:0] ref_sym(input logic [3:0] w);
    logic [3:0] g [3];
    logic [2:0] s;
    g[0] = 4'b1111;
    g[1] = 4'b1011;
    g[2] = 4'b1101;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        if (g[i][j]) s[i] = s[i] ^ w[j];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hb = 3'b000;
    end else begin
      if (bus_b.in_valid && bus_b.in_ready) begin
        qb.push_back({(TAIL_B == 0) && bus_b.in_last, ref_sym({bus_b.in_bit, hb})});
        hb = {bus_b.in_bit, hb[2:1]};
        if (bus_b.in_last) begin
          for (int t = 0; t < TAIL_B; t++) begin
            qb.push_back({t == TAIL_B - 1, ref_sym({1'b0, hb})});
            hb = {1'b0, hb[2:1]};
          end
          hb = 3'b000;
        end
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        nb_sym++;
        if (qb.size() == 0) chk("b_extra_symbol", 1, 0);
        else chk("b_sym", {bus_b.out_last, bus_b.out_sym}, qb.pop_front());
      end
    end
  end

  task automatic wait_acc_b();
    int t = 0;
    @(negedge clk);
    while (!bus_b.in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("b_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence
  logic [23:0] seq_main;
  logic [23:0] seq_one;
  int          n_main, n_one;
  int          total, exp_syms, len_b, t_drain;

  initial begin
`ifdef CONV_ENCODER_TAIL_EN
    seq_main = {6'b0, 3'b111, 3'b010, 3'b010, 3'b000, 3'b001, 3'b011};
    n_main   = 6;
    seq_one  = {15'b0, 3'b111, 3'b001, 3'b011};
    n_one    = 3;
`else
    seq_main = {12'b0, 3'b110, 3'b000, 3'b001, 3'b011};
    n_main   = 4;
    seq_one  = {21'b0, 3'b111};
    n_one    = 1;
`endif
    bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0; bus_b.in_last = 1'b0;

    #12;
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_sym", bus_a.out_sym, 0);
    chk("rst_out_last", bus_a.out_last, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_in_ready", bus_a.in_ready, 1);
    #10 rst_n = 1'b1;

    // frame 1,0,1,1 with out_ready held high
    send_a(16'b1101, 4, 1'b1);
    @(negedge clk);
`ifdef CONV_ENCODER_TAIL_EN
    chk("flush1_in_ready", bus_a.in_ready, 0);
    chk("flush1_busy", busy_a, 1);
    @(negedge clk);
    chk("flush2_in_ready", bus_a.in_ready, 0);
    @(negedge clk);
    chk("post_flush_in_ready", bus_a.in_ready, 1);
    @(negedge clk);
    chk("idle_busy", busy_a, 0);
`else
    chk("last_in_ready", bus_a.in_ready, 1);
    chk("last_busy", busy_a, 1);
    @(negedge clk);
    chk("idle_busy", busy_a, 0);
`endif
    expect_a("frame_main", seq_main, n_main);

    // next frame begins from a cleared shift register
    send_a(16'b1, 1, 1'b1);
    expect_a("frame_single", seq_one, n_one);

    // same frame under a stuttering out_ready
    bp_en = 1'b1;
    send_a(16'b1101, 4, 1'b1);
    expect_a("frame_backpressure", seq_main, n_main);
    bp_en = 1'b0;

    // reset mid-frame, two bits in, nothing terminated
    send_a(16'b01, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus_a.out_valid, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_out_sym", bus_a.out_sym, 0);
    qa.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    send_a(16'b1, 1, 1'b1);
    expect_a("after_reset", seq_one, n_one);

    // random frames into the K=4, N=3 instance
    total    = 0;
    exp_syms = 0;
    @(posedge clk);
    #1;
    while (total < 1000) begin
      len_b = $urandom_range(1, 40);
      if (len_b > 1000 - total) len_b = 1000 - total;
      for (int i = 0; i < len_b; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          bus_b.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        bus_b.in_valid = 1'b1;
        bus_b.in_bit   = 1'($urandom_range(0, 1));
        bus_b.in_last  = (i == len_b - 1);
        wait_acc_b();
      end
      bus_b.in_valid = 1'b0;
      bus_b.in_last  = 1'b0;
      total    += len_b;
      exp_syms += len_b + TAIL_B;
    end
    t_drain = 0;
    while ((qb.size() != 0 || busy_b) && t_drain < 200) begin
      @(negedge clk);
      t_drain++;
    end
    repeat (3) @(negedge clk);
    chk("b_symbol_count", nb_sym, exp_syms);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_idle", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
